// File: rtl/mult_pkg.sv
// mult_pkg: shared multiplier widths and the operation tag carried alongside products
package mult_pkg;
    localparam int MULT_W = 32;
    localparam int PROD_W = 64;
    localparam int TAG_IDXW = 3;
    typedef struct packed {
        logic valid;
        logic [TAG_IDXW-1:0] idx;
    } mult_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first valid requester found scanning upward from ptr with wrap-around
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic any
);
    logic [W-1:0] lo, hi;
    logic lo_any, hi_any;
    // lowest valid at or above ptr wins; otherwise wrap to the lowest valid overall
    always_comb begin
        lo = '0;
        hi = '0;
        lo_any = 1'b0;
        hi_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (valid[j]) begin
                lo = W'(j);
                lo_any = 1'b1;
            end
            if (valid[j] && W'(j) >= ptr) begin
                hi = W'(j);
                hi_any = 1'b1;
            end
        end
        idx = hi_any ? hi : lo;
        any = lo_any;
        grant = lo_any ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/umultiplier.sv
// umultiplier: unsigned 32x32 multiplier with a fixed LAT-stage output pipeline and no reset
module umultiplier
    import mult_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic [MULT_W-1:0] in1,
    input  logic [MULT_W-1:0] in2,
    output logic [PROD_W-1:0] out
);
    logic [PROD_W-1:0] pipe [LAT];
    // full-width product enters stage 0 and shifts toward the output
    always_ff @(posedge clk) begin
        pipe[0] <= PROD_W'(in1) * PROD_W'(in2);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign out = pipe[LAT-1];
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined multiplier with tagged product return
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int MULT_LAT = 1,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic clk,
    input  logic rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [MULT_W*NREQ-1:0] req_in1,
    input  logic [MULT_W*NREQ-1:0] req_in2,
    output logic [NREQ-1:0] req_ready,
    output logic [NREQ-1:0] rsp_valid,
    output logic [PROD_W-1:0] rsp_data,
    output logic [3:0] in_flight,
    output logic busy
);
    logic [IDXW-1:0] ptr, win;
    logic [NREQ-1:0] grant;
    logic any, xfer;
    logic [MULT_W-1:0] in1, in2;
    mult_tag_t tags [MULT_LAT];

    rr_pick #(.N(NREQ)) u_pick (
        .valid(req_valid),
        .ptr(ptr),
        .grant(grant),
        .idx(win),
        .any(any)
    );

    umultiplier #(.LAT(MULT_LAT)) u_mult (
        .clk(clk),
        .in1(in1),
        .in2(in2),
        .out(rsp_data)
    );

    assign req_ready = rst ? '0 : grant;
    assign xfer = any & ~rst;
    assign busy = in_flight != 4'd0;

    // winner's operands feed the multiplier; zero when nobody is granted
    always_comb begin
        in1 = '0;
        in2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                in1 = req_in1[MULT_W*i +: MULT_W];
                in2 = req_in2[MULT_W*i +: MULT_W];
            end
        end
    end

    // pointer advance past the winner and tag shift aligned with the multiplier pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < MULT_LAT; i++) tags[i] <= '0;
        end else begin
            if (xfer) ptr <= (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;
            tags[0] <= '{valid: xfer, idx: TAG_IDXW'(win)};
            for (int i = 1; i < MULT_LAT; i++) tags[i] <= tags[i-1];
        end
    end

    // retiring tag steers the response pulse and in-flight count is the number of live tags
    always_comb begin
        rsp_valid = '0;
        in_flight = '0;
        for (int i = 0; i < NREQ; i++)
            rsp_valid[i] = tags[MULT_LAT-1].valid && tags[MULT_LAT-1].idx == TAG_IDXW'(i);
        for (int i = 0; i < MULT_LAT; i++) in_flight = in_flight + 4'(tags[i].valid);
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one `umultiplier` instance (32x32 unsigned, 64-bit product, fixed pipeline latency) among `NREQ` requesters. Each requester presents operands with a valid/ready handshake. Each accepted operation is tagged with its requester index and tracked through the multiplier pipeline, so the product returns to the requester that issued it. The block sits between the requesting units and the multiplier datapath, and is the only driver of the multiplier inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MULT_LAT`, 1: cycles from operands sampled at a clk edge to product valid on `umultiplier.out`, 1..8.
- `IDXW`, $clog2(NREQ): index width, derived; not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has an operation pending.
- `req_in1`  in  32*NREQ  flattened operand 1; bits [32i+31:32i] belong to requester i.
- `req_in2`  in  32*NREQ  flattened operand 2, same packing as `req_in1`.
- `req_ready`  out  NREQ  one-hot grant; the transfer occurs when `req_valid[i] && req_ready[i]`.
- `rsp_valid`  out  NREQ  one-hot one-cycle pulse; the product for requester i is on `rsp_data`.
- `rsp_data`  out  64  product of the returning operation; shared by all requesters.
- `in_flight`  out  4  number of operations inside the multiplier pipeline.
- `busy`  out  1  `in_flight != 0`.

## Operation
- Arbitration is round-robin from pointer `ptr` (IDXW bits). The winner is the first i with `req_valid[i]`, scanning ptr, ptr+1, … modulo NREQ.
- `req_ready` is combinational from `req_valid` and `ptr`. It is all-zero when no requester is valid or `rst` is high.
- A request is never ready unless it is valid.
- After a transfer by requester w, `ptr <= (w+1) mod NREQ`. With no transfer, `ptr` holds.
- One operation is accepted per cycle at most. There is no response backpressure, so the issue rate is not limited by the pipeline.
- Multiplier operands are muxed from the winner. They are driven to 0 when there is no grant.
- Tag pipeline: MULT_LAT stages of {valid, IDXW index}, shifted every cycle and cleared by `rst`. Stage 0 loads {transfer, w}.
- At the last stage, `rsp_valid[idx] = valid` and `rsp_data = umultiplier.out`. `rsp_data` is don't-care when no `rsp_valid` bit is set.
- `in_flight` counts set valid bits in the tag pipeline, maximum MULT_LAT.
- When a transfer and a retire happen in the same cycle, the count is unchanged.
- The product is the full 64-bit unsigned result with no truncation: 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
- Requesters may change operands or drop `req_valid` freely while not granted.

## Timing
- Reset values: `ptr`=0, tag pipeline cleared, `rsp_valid`=0, `in_flight`=0, `busy`=0. `req_ready`=0 while `rst` is high.
- Latency: a transfer at edge N gives `rsp_valid` during the cycle after edge N+MULT_LAT−1, i.e. MULT_LAT cycles after acceptance.
- Back-to-back transfers from different requesters retire in issue order, one per cycle.
- Reset mid-operation: all in-flight operations are discarded, and no `rsp_valid` fires for them after `rst` deasserts.
- `umultiplier` has no reset. Its stale output is never qualified because the tag pipeline is clear.
- A single requester holding `req_valid` is granted every cycle, giving a full-throughput stream.
- All requesters valid: grant order is 0,1,2,3,0,… from reset.
- `ptr` wrap-around: after requester NREQ−1 wins, `ptr` returns to 0.

## Structure
- Shared package `mult_pkg`:
  - constants `MULT_W=32` and `PROD_W=64`;
  - typedef `mult_tag_t` = {valid, idx}, used by this block and future multiplier clients.
- Sub-module: the existing `umultiplier` is instantiated once inside; its ports are `in1`, `in2`, `clk`, `out`.
- Round-robin logic stays inline.
- Optional helper sub-module `rr_pick`: combinational first-valid-from-pointer, reusable by other arbiters.

## Test plan
- Reset then a single request: `req_valid`=0001 with in1=3, in2=5 → `req_ready`=0001; after MULT_LAT cycles `rsp_valid`=0001 with `rsp_data`=15, and `in_flight` returns to 0.
- All four requesters valid continuously, each with in1=i+1, in2=0x10 → grants 0,1,2,3,0 on consecutive cycles; responses 0x10,0x20,0x30,0x40 arrive in order, each on its own `rsp_valid` bit.
- Max operands 0xFFFFFFFF x 0xFFFFFFFF from requester 2 → `rsp_data`=0xFFFFFFFE00000001 with `rsp_valid`=0100.
- Pointer fairness: requester 1 alone wins, then requesters 0 and 3 become valid together → requester 3 is granted first (ptr=2), then requester 0.
- Assert `rst` for 1 cycle while 2 operations are in flight (MULT_LAT=3 build) → no `rsp_valid` afterwards; `in_flight`=0 and `busy`=0 immediately.
- Requester drops `req_valid` while not granted → it gets no grant and no response; the other requesters are unaffected.
